axis_frame_tagger: RTL and testbench

//  Upstream stage of the stream max-finder. Takes an untagged AXI-Stream sample stream
//  and inserts TLAST every frame_len accepted beats, so the downstream max-finder sees

---
 rtl/axis_pkg.sv | 20 ++
 rtl/axis_skid_buffer.sv | 77 +++++++
 rtl/axis_frame_tagger.sv | 104 ++++++++++
 tb/tb_axis_frame_tagger.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared stream definitions for the axis_* blocks: default widths, beat layout and
// the occupancy states of the 2-entry register slice.
package axis_pkg;

    localparam int AXIS_STREAM_WIDTH = 32;
    localparam int AXIS_LEN_WIDTH    = 16;
    localparam int AXIS_CNT_WIDTH    = 32;

    typedef struct packed {
        logic [AXIS_STREAM_WIDTH-1:0] data;
        logic                         last;
    } axis_beat_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic fully-registered 2-entry register slice: an output register plus one skid
// register, with a registered ready so no combinational path crosses the slice.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter int WIDTH = $bits(axis_beat_t)
) (
    input  logic             ACLK,
    input  logic             ARESET_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             accept;
    logic             xfer;

    assign m_valid = (state_q != SKID_EMPTY);
    assign m_data  = out_q;
    assign s_ready = ready_q;
    assign accept  = s_valid && ready_q;
    assign xfer    = m_valid && m_ready;

    // Ready is only ever low in FULL, so no input can arrive while the skid is occupied.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_d   = s_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (xfer && accept) begin
                    out_d = s_data;
                end else if (xfer) begin
                    state_d = SKID_EMPTY;
                end else if (accept) begin
                    skid_d  = s_data;
                    state_d = SKID_FULL;
                end
            end
            SKID_FULL: begin
                if (xfer) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET_n) begin
        if (!ARESET_n) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != SKID_FULL);
        end
    end

endmodule

// File: rtl/axis_frame_tagger.sv
// Inserts TLAST every frame_len accepted beats of an untagged sample stream and keeps
// frame statistics; buffering is delegated to a 2-entry register slice.
module axis_frame_tagger
    import axis_pkg::*;
#(
    parameter int STREAM_WIDTH = AXIS_STREAM_WIDTH,
    parameter int LEN_WIDTH    = AXIS_LEN_WIDTH,
    parameter int CNT_WIDTH    = AXIS_CNT_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET_n,
    input  logic [STREAM_WIDTH-1:0] s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
    output logic [STREAM_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic                    frame_done,
    output logic [CNT_WIDTH-1:0]    frames_sent
);

    // Same layout as axis_beat_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [STREAM_WIDTH-1:0] data;
        logic                    last;
    } beat_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [LEN_WIDTH-1:0] cur_len;
    logic                 frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0] frames_sent_q, frames_sent_d;
    logic                 accept;
    logic                 in_last;
    logic                 xfer_last;
    beat_t                in_beat;
    beat_t                out_beat;

    assign accept  = s_tvalid && s_tready;
    assign eff_len = (cfg_frame_len == '0) ? LEN_ONE : cfg_frame_len;
    // The first beat of a frame uses the live config; later beats use the latched length.
    assign cur_len = (cnt_q == '0) ? eff_len : len_q;
    assign in_last = (cnt_q == (cur_len - LEN_ONE));
    assign in_beat = '{data: s_tdata, last: in_last};

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (accept) begin
            if (cnt_q == '0) begin
                len_d = eff_len;
            end
            cnt_d = in_last ? '0 : (cnt_q + LEN_ONE);
        end
    end

    assign xfer_last = m_tvalid && m_tready && m_tlast;

    always_comb begin
        frame_done_d  = xfer_last;
        frames_sent_d = frames_sent_q;
        if (xfer_last) begin
            frames_sent_d = frames_sent_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_n) begin
        if (!ARESET_n) begin
            cnt_q         <= '0;
            len_q         <= LEN_ONE;
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            frame_done_q  <= frame_done_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    axis_skid_buffer #(
        .WIDTH ($bits(beat_t))
    ) u_skid (
        .ACLK     (ACLK),
        .ARESET_n (ARESET_n),
        .s_data   (in_beat),
        .s_valid  (s_tvalid),
        .s_ready  (s_tready),
        .m_data   (out_beat),
        .m_valid  (m_tvalid),
        .m_ready  (m_tready)
    );

    assign m_tdata     = out_beat.data;
    assign m_tlast     = out_beat.last;
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_axis_frame_tagger.sv
// Scoreboard bench for axis_frame_tagger: accepted beats are tagged by a frame-position
// model and queued; an output monitor pops and compares on every downstream transfer.
module tb_axis_frame_tagger;

    localparam int SW = 32;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET_n = 1'b0;
    logic [SW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [LW-1:0] cfg_frame_len;
    logic [SW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          frame_done;
    logic [CW-1:0] frames_sent;

    axis_frame_tagger #(
        .STREAM_WIDTH (SW),
        .LEN_WIDTH    (LW),
        .CNT_WIDTH    (CW)
    ) dut (
        .ACLK          (ACLK),
        .ARESET_n      (ARESET_n),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .cfg_frame_len (cfg_frame_len),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .frame_done    (frame_done),
        .frames_sent   (frames_sent)
    );

    always #5 ACLK = ~ACLK;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [SW:0]   sb_q[$];        // {data, last} of beats accepted but not yet delivered
    int            frame_pos = 0;  // beats of the current frame already accepted
    int            frame_len_m = 1;
    logic          armed = 1'b0;   // DUT has seen a clock edge since reset release
    logic          exp_fd = 1'b0;
    logic [CW-1:0] exp_fs = '0;
    logic          prev_stall = 1'b0;
    logic [SW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          in_acc;
    logic [SW-1:0] in_d;
    logic [LW-1:0] in_cfg;
    logic [SW:0]   exp_beat;
    logic [SW-1:0] next_data = '0;
    int            cyc_used;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge ACLK or negedge ARESET_n) begin
        if (!ARESET_n) armed <= 1'b0;
        else           armed <= 1'b1;
    end

    // Input side: a beat accepted at the coming edge gets its frame position and is queued.
    always @(negedge ACLK) begin
        if (!ARESET_n) frame_pos = 0;
        in_acc = ARESET_n && s_tvalid && s_tready;
        in_d   = s_tdata;
        in_cfg = cfg_frame_len;
        #2;
        if (in_acc) begin
            if (frame_pos == 0) frame_len_m = (in_cfg == 0) ? 1 : int'(in_cfg);
            frame_pos++;
            if (frame_pos == frame_len_m) begin
                sb_q.push_back({in_d, 1'b1});
                frame_pos = 0;
            end else begin
                sb_q.push_back({in_d, 1'b0});
            end
            $display("IN  data=%08h last=%0d t=%0t", in_d, sb_q[$][0], $time);
        end
    end

    // Output side: occupancy, handshake, statistics and AXI hold checks.
    always @(negedge ACLK) begin
        if (!ARESET_n) begin
            sb_q.delete();
            exp_fd     = 1'b0;
            exp_fs     = '0;
            prev_stall = 1'b0;
        end else begin
            check("m_tvalid_occupancy", 64'(m_tvalid), 64'(sb_q.size() != 0));
            check("s_tready_occupancy", 64'(s_tready), 64'(armed && (sb_q.size() < 2)));
            check("frame_done", 64'(frame_done), 64'(exp_fd));
            check("frames_sent", 64'(frames_sent), 64'(exp_fs));
            if (prev_stall) begin
                check("hold_tdata", 64'(m_tdata), 64'(prev_data));
                check("hold_tlast", 64'(m_tlast), 64'(prev_last));
            end
            exp_fd = 1'b0;
            if (m_tvalid && m_tready && sb_q.size() != 0) begin
                exp_beat = sb_q.pop_front();
                check("out_tdata", 64'(m_tdata), 64'(exp_beat[SW:1]));
                check("out_tlast", 64'(m_tlast), 64'(exp_beat[0]));
                $display("OUT data=%08h last=%0d t=%0t", m_tdata, m_tlast, $time);
                if (exp_beat[0]) begin
                    exp_fd = 1'b1;
                    exp_fs = exp_fs + 1;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic run_phase(input int n_beats, input int pv, input int pr,
                             input int cfg_a, input int cfg_b, input int switch_at,
                             input int stall_at, input int stall_len, input bit rnd_data,
                             output int cycles);
        int  sent = 0;
        int  cyc = 0;
        logic acc;
        cfg_frame_len = LW'(cfg_a);
        while (sent < n_beats && cyc < n_beats * 20 + 100) begin
            if (!s_tvalid) begin
                s_tvalid = ($urandom_range(99) < pv);
                s_tdata  = rnd_data ? SW'($urandom) : next_data;
            end
            m_tready = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0
                                                                       : ($urandom_range(99) < pr);
            @(negedge ACLK);
            acc = s_tvalid && s_tready;
            @(posedge ACLK);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                next_data = next_data + 1;
                s_tvalid  = 1'b0;
                if (sent == switch_at) cfg_frame_len = LW'(cfg_b);
            end
        end
        check("phase_beats_accepted", 64'(sent), 64'(n_beats));
        s_tvalid = 1'b0;
        cycles = cyc;
    endtask

    task automatic drain();
        int n = 0;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET_n = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET_n = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        s_tvalid      = 1'b0;
        s_tdata       = '0;
        m_tready      = 1'b0;
        cfg_frame_len = LW'(4);
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frames_sent", 64'(frames_sent), 64'd0);
        ARESET_n = 1'b1;
        @(posedge ACLK);
        #1;

        // L=4, continuous flow: data 1..8, one beat per cycle
        next_data = 1;
        run_phase(8, 100, 100, 4, 4, 0, -1, 0, 1'b0, cyc_used);
        check("l4_no_bubble_cycles", 64'(cyc_used), 64'd8);
        drain();
        check("l4_frames_sent", 64'(frames_sent), 64'd2);

        // L=3 with a 3-cycle downstream stall mid-frame
        next_data = 10;
        run_phase(3, 100, 100, 3, 3, 0, 1, 3, 1'b0, cyc_used);
        drain();
        check("l3_frames_sent", 64'(frames_sent), 64'd3);

        // cfg=0: every beat is its own frame
        run_phase(6, 100, 70, 0, 0, 0, -1, 0, 1'b1, cyc_used);
        drain();
        check("l0_frames_sent", 64'(frames_sent), 64'd9);

        // L=5 changed to 2 after beat 2: frames of 5, 2, 2
        run_phase(9, 100, 80, 5, 2, 2, -1, 0, 1'b1, cyc_used);
        drain();
        check("cfg_change_frames_sent", 64'(frames_sent), 64'd12);

        // Reset mid-frame after two beats of L=4
        run_phase(2, 100, 0, 4, 4, 0, -1, 0, 1'b1, cyc_used);
        #2;
        ARESET_n = 1'b0;
        #1;
        check("async_rst_s_tready", 64'(s_tready), 64'd0);
        check("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("async_rst_m_tdata", 64'(m_tdata), 64'd0);
        check("async_rst_m_tlast", 64'(m_tlast), 64'd0);
        check("async_rst_frames_sent", 64'(frames_sent), 64'd0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESET_n = 1'b1;
        @(posedge ACLK);
        #1;
        run_phase(8, 80, 80, 4, 4, 0, -1, 0, 1'b1, cyc_used);
        drain();
        check("post_rst_frames_sent", 64'(frames_sent), 64'd2);

        // Maximum length: no TLAST within 20 beats
        run_phase(20, 100, 100, 16'hFFFF, 16'hFFFF, 0, -1, 0, 1'b1, cyc_used);
        drain();
        check("lmax_frames_sent", 64'(frames_sent), 64'd2);

        // Random handshakes, L=7, 1000 beats
        do_reset();
        run_phase(1000, 50, 50, 7, 7, 0, -1, 0, 1'b1, cyc_used);
        drain();
        check("random_frames_sent", 64'(frames_sent), 64'd142);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
